// File: rtl/psx_ram_pkg.sv
// Shared types and constants for the PSX main-RAM requester.
package psx_ram_pkg;

  typedef enum logic [1:0] {
    CL_NONE = 2'd0,
    CL_CPU  = 2'd1,
    CL_IC   = 2'd2,
    CL_DMA  = 2'd3
  } client_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_WAIT_ACC  = 3'd3,
    ST_WAIT_DMA  = 3'd4
  } req_state_t;

  localparam int          RAM_ADDR_W = 27;
  localparam logic [31:0] DEADDATA   = 32'hDEADDEAD;

endpackage

// File: rtl/psx_ram_dma_unpack.sv
// DMA burst receiver: counts the words of one read burst and forwards them
// with one cycle of latency, flagging the final word with dma_done.
import psx_ram_pkg::*;

module psx_ram_dma_unpack (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  start_cnt,
  input  logic        abort,
  input  logic        word_wr,
  input  logic [31:0] word_data,
  output logic        last,
  output logic        dma_wr,
  output logic [31:0] dma_data,
  output logic        dma_done
);

  logic       active;
  logic [1:0] wcnt;
  logic [1:0] cur_cnt;
  logic       accept;

  // A word strobed together with the acceptance already belongs to the burst.
  assign accept  = word_wr && (start || active);
  assign cur_cnt = start ? start_cnt : wcnt;
  assign last    = accept && (cur_cnt == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      wcnt     <= 2'd0;
      dma_wr   <= 1'b0;
      dma_data <= 32'd0;
      dma_done <= 1'b0;
    end else begin
      dma_wr   <= 1'b0;
      dma_done <= 1'b0;
      if (abort) begin
        active   <= 1'b0;
        wcnt     <= 2'd0;
        dma_done <= 1'b1;
      end else if (accept) begin
        dma_wr   <= 1'b1;
        dma_data <= word_data;
        if (last) begin
          active   <= 1'b0;
          wcnt     <= 2'd0;
          dma_done <= 1'b1;
        end else begin
          active <= 1'b1;
          wcnt   <= cur_cnt - 2'd1;
        end
      end else if (start) begin
        active <= 1'b1;
        wcnt   <= start_cnt;
      end
    end
  end

endmodule

// File: rtl/psx_ram_requester.sv
// Arbitrates CPU, icache and DMA clients onto the single PSX main-RAM port.
// Define RAM_TIMEOUT_EN to build the response timeout counter.
import psx_ram_pkg::*;

module psx_ram_requester #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ADDR_W         = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_rnw,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [3:0]            cpu_be,
  input  logic [31:0]           cpu_di,
  output logic                  cpu_done,
  output logic [31:0]           cpu_do,
  input  logic                  ic_req,
  input  logic [ADDR_W-1:0]     ic_addr,
  output logic                  ic_done,
  input  logic                  dma_req,
  input  logic [ADDR_W-1:0]     dma_addr,
  input  logic [1:0]            dma_cnt,
  output logic                  dma_wr,
  output logic [31:0]           dma_data,
  output logic                  dma_done,
  output logic                  ram_req,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_rnw,
  output logic [3:0]            ram_be,
  output logic [31:0]           ram_di,
  output logic                  ram_dma,
  output logic [1:0]            ram_dmacnt,
  output logic                  ram_iscache,
  input  logic                  ram_done,
  input  logic [31:0]           ram_do32,
  input  logic                  ram_reqprocessed,
  input  logic                  ram_dma_wr,
  input  logic [31:0]           ram_dma_data,
  input  logic                  ram_idle,
  output logic                  err_overrun,
  output logic                  err_timeout
);

  req_state_t state;
  client_t    sel;
  client_t    owner;
  logic       own_rnw;

  logic              cpu_pend, ic_pend, dma_pend;
  logic              cpu_rnw_q;
  logic [ADDR_W-1:0] cpu_addr_q, ic_addr_q, dma_addr_q;
  logic [3:0]        cpu_be_q;
  logic [31:0]       cpu_di_q;
  logic [1:0]        dma_cnt_q;

  logic        cpu_clr, ic_clr, dma_clr;
  logic        tmo_hit;
  logic        dma_start, dma_abort, dma_last;
  logic [31:0] rd_data;

  assign cpu_clr   = (state == ST_ISSUE) && (sel == CL_CPU);
  assign ic_clr    = (state == ST_ISSUE) && (sel == CL_IC);
  assign dma_clr   = (state == ST_ISSUE) && (sel == CL_DMA);
  assign dma_start = (state == ST_WAIT_ACC) && ram_reqprocessed;
  assign dma_abort = tmo_hit && (owner == CL_DMA);
  assign rd_data   = ram_done ? ram_do32 : DEADDATA;

  // Client request capture; a repeat pulse while still pending is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_pend    <= 1'b0;
      ic_pend     <= 1'b0;
      dma_pend    <= 1'b0;
      cpu_rnw_q   <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_be_q    <= 4'd0;
      cpu_di_q    <= 32'd0;
      ic_addr_q   <= '0;
      dma_addr_q  <= '0;
      dma_cnt_q   <= 2'd0;
      err_overrun <= 1'b0;
    end else begin
      if (cpu_req && !cpu_pend) begin
        cpu_pend   <= 1'b1;
        cpu_rnw_q  <= cpu_rnw;
        cpu_addr_q <= cpu_addr;
        cpu_be_q   <= cpu_be;
        cpu_di_q   <= cpu_di;
      end else if (cpu_clr) begin
        cpu_pend <= 1'b0;
      end
      if (ic_req && !ic_pend) begin
        ic_pend   <= 1'b1;
        ic_addr_q <= ic_addr;
      end else if (ic_clr) begin
        ic_pend <= 1'b0;
      end
      if (dma_req && !dma_pend) begin
        dma_pend   <= 1'b1;
        dma_addr_q <= dma_addr;
        dma_cnt_q  <= dma_cnt;
      end else if (dma_clr) begin
        dma_pend <= 1'b0;
      end
      if ((cpu_req && cpu_pend) || (ic_req && ic_pend) || (dma_req && dma_pend)) begin
        err_overrun <= 1'b1;
      end
    end
  end

  // Request FSM; RAM attributes are only non-zero during the ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      sel         <= CL_NONE;
      owner       <= CL_NONE;
      own_rnw     <= 1'b0;
      ram_req     <= 1'b0;
      ram_addr    <= '0;
      ram_rnw     <= 1'b0;
      ram_be      <= 4'd0;
      ram_di      <= 32'd0;
      ram_dma     <= 1'b0;
      ram_dmacnt  <= 2'd0;
      ram_iscache <= 1'b0;
      cpu_done    <= 1'b0;
      cpu_do      <= 32'd0;
      ic_done     <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      ic_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ram_idle && (dma_pend || cpu_pend || ic_pend)) begin
            ram_req <= 1'b1;
            state   <= ST_ISSUE;
            if (dma_pend) begin
              sel         <= CL_DMA;
              own_rnw     <= 1'b1;
              ram_addr    <= RAM_ADDR_W'(dma_addr_q);
              ram_rnw     <= 1'b1;
              ram_be      <= 4'hF;
              ram_di      <= 32'd0;
              ram_dma     <= 1'b1;
              ram_dmacnt  <= dma_cnt_q;
              ram_iscache <= 1'b0;
            end else if (cpu_pend) begin
              sel         <= CL_CPU;
              own_rnw     <= cpu_rnw_q;
              ram_addr    <= RAM_ADDR_W'(cpu_addr_q);
              ram_rnw     <= cpu_rnw_q;
              ram_be      <= cpu_be_q;
              ram_di      <= cpu_di_q;
              ram_dma     <= 1'b0;
              ram_dmacnt  <= 2'd0;
              ram_iscache <= 1'b0;
            end else begin
              sel         <= CL_IC;
              own_rnw     <= 1'b1;
              ram_addr    <= RAM_ADDR_W'(ic_addr_q);
              ram_rnw     <= 1'b1;
              ram_be      <= 4'hF;
              ram_di      <= 32'd0;
              ram_dma     <= 1'b0;
              ram_dmacnt  <= 2'd0;
              ram_iscache <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          ram_req     <= 1'b0;
          ram_addr    <= '0;
          ram_rnw     <= 1'b0;
          ram_be      <= 4'd0;
          ram_di      <= 32'd0;
          ram_dma     <= 1'b0;
          ram_dmacnt  <= 2'd0;
          ram_iscache <= 1'b0;
          owner       <= sel;
          state       <= (sel == CL_DMA) ? ST_WAIT_ACC : ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (ram_done || tmo_hit) begin
            if (owner == CL_CPU) begin
              cpu_done <= 1'b1;
              if (own_rnw) cpu_do <= rd_data;
            end else begin
              ic_done <= 1'b1;
            end
            owner <= CL_NONE;
            state <= ST_IDLE;
          end
        end
        ST_WAIT_ACC: begin
          if (ram_reqprocessed) begin
            state <= dma_last ? ST_IDLE : ST_WAIT_DMA;
            if (dma_last) owner <= CL_NONE;
          end else if (tmo_hit) begin
            owner <= CL_NONE;
            state <= ST_IDLE;
          end
        end
        ST_WAIT_DMA: begin
          if (dma_last || tmo_hit) begin
            owner <= CL_NONE;
            state <= ST_IDLE;
          end
        end
        default: begin
          owner <= CL_NONE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RAM_TIMEOUT_EN
  logic [11:0] tmo_cnt;
  logic        waiting;
  logic        ram_resp;

  assign waiting  = (state == ST_WAIT_DONE) || (state == ST_WAIT_ACC) || (state == ST_WAIT_DMA);
  assign ram_resp = ram_done || ram_reqprocessed || ram_dma_wr;
  assign tmo_hit  = waiting && !ram_resp && (tmo_cnt == 12'(TIMEOUT_CYCLES - 1));

  // Silence counter; any RAM response restarts the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= 12'd0;
      err_timeout <= 1'b0;
    end else begin
      if (!waiting || ram_resp || tmo_hit) tmo_cnt <= 12'd0;
      else                                 tmo_cnt <= tmo_cnt + 12'd1;
      if (tmo_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  psx_ram_dma_unpack u_unpack (
    .clk       (clk),
    .reset     (reset),
    .start     (dma_start),
    .start_cnt (dma_cnt_q),
    .abort     (dma_abort),
    .word_wr   (ram_dma_wr),
    .word_data (ram_dma_data),
    .last      (dma_last),
    .dma_wr    (dma_wr),
    .dma_data  (dma_data),
    .dma_done  (dma_done)
  );

endmodule

// File: tb/tb_psx_ram_requester.sv
// Directed self-checking bench for psx_ram_requester.
module tb_psx_ram_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rnw;
  logic [22:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_di;
  logic        cpu_done;
  logic [31:0] cpu_do;
  logic        ic_req;
  logic [22:0] ic_addr;
  logic        ic_done;
  logic        dma_req;
  logic [22:0] dma_addr;
  logic [1:0]  dma_cnt;
  logic        dma_wr;
  logic [31:0] dma_data;
  logic        dma_done;
  logic        ram_req;
  logic [26:0] ram_addr;
  logic        ram_rnw;
  logic [3:0]  ram_be;
  logic [31:0] ram_di;
  logic        ram_dma;
  logic [1:0]  ram_dmacnt;
  logic        ram_iscache;
  logic        ram_done;
  logic [31:0] ram_do32;
  logic        ram_reqprocessed;
  logic        ram_dma_wr;
  logic [31:0] ram_dma_data;
  logic        ram_idle;
  logic        err_overrun;
  logic        err_timeout;

  always #5 clk = ~clk;

  psx_ram_requester dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_di(cpu_di), .cpu_done(cpu_done), .cpu_do(cpu_do),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_cnt(dma_cnt),
    .dma_wr(dma_wr), .dma_data(dma_data), .dma_done(dma_done),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_rnw(ram_rnw), .ram_be(ram_be),
    .ram_di(ram_di), .ram_dma(ram_dma), .ram_dmacnt(ram_dmacnt), .ram_iscache(ram_iscache),
    .ram_done(ram_done), .ram_do32(ram_do32), .ram_reqprocessed(ram_reqprocessed),
    .ram_dma_wr(ram_dma_wr), .ram_dma_data(ram_dma_data), .ram_idle(ram_idle),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Pulse counters and DMA word log, sampled mid-cycle.
  int          n_ram_req = 0, n_cpu_done = 0, n_ic_done = 0;
  int          n_dma_wr = 0, n_dma_done = 0, dma_done_at = 0;
  logic [31:0] dma_log [0:15];

  always @(negedge clk) begin
    if (ram_req === 1'b1) n_ram_req++;
    if (cpu_done === 1'b1) n_cpu_done++;
    if (ic_done === 1'b1) n_ic_done++;
    if (dma_wr === 1'b1) begin
      dma_log[n_dma_wr % 16] = dma_data;
      n_dma_wr++;
    end
    if (dma_done === 1'b1) begin
      n_dma_done++;
      dma_done_at = n_dma_wr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_pulse(input logic rnw, input logic [22:0] a, input logic [3:0] be,
                           input logic [31:0] di);
    tick();
    cpu_req = 1'b1; cpu_rnw = rnw; cpu_addr = a; cpu_be = be; cpu_di = di;
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ram_req === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic give_done(input logic [31:0] d);
    tick();
    ram_done = 1'b1; ram_do32 = d;
    tick();
    ram_done = 1'b0; ram_do32 = 32'd0;
  endtask

  int n, b_req, b_cpu, b_ic, b_wr, b_done;
  logic [31:0] exp_words [0:3];

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_rnw = 1'b0; cpu_addr = 23'd0; cpu_be = 4'd0;
    cpu_di = 32'd0; ic_req = 1'b0; ic_addr = 23'd0; dma_req = 1'b0; dma_addr = 23'd0;
    dma_cnt = 2'd0; ram_done = 1'b0; ram_do32 = 32'd0; ram_reqprocessed = 1'b0;
    ram_dma_wr = 1'b0; ram_dma_data = 32'd0; ram_idle = 1'b1;
    exp_words[0] = 32'hA0A0_0001; exp_words[1] = 32'hB1B1_0002;
    exp_words[2] = 32'hC2C2_0003; exp_words[3] = 32'hD3D3_0004;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ram_req", 32'(ram_req), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_dones", 32'({cpu_done, ic_done, dma_wr, dma_done}), 32'd0);
    check("rst_cpu_do", cpu_do, 32'd0);
    check("rst_errs", 32'({err_overrun, err_timeout}), 32'd0);

    // CPU write
    b_cpu = n_cpu_done;
    cpu_pulse(1'b0, 23'h000100, 4'b0011, 32'h12345678);
    wait_req(n);
    check("wr_issue_found", 32'(n >= 0), 32'd1);
    check("wr_rnw", 32'(ram_rnw), 32'd0);
    check("wr_addr", 32'(ram_addr), 32'h0000100);
    check("wr_be", 32'(ram_be), 32'h3);
    check("wr_di", ram_di, 32'h12345678);
    check("wr_type", 32'({ram_dma, ram_iscache}), 32'd0);
    @(negedge clk);
    check("wr_req_one_cycle", 32'(ram_req), 32'd0);
    give_done(32'h0);
    @(negedge clk);
    check("wr_cpu_done", 32'(cpu_done), 32'd1);
    tick();
    check("wr_done_count", 32'(n_cpu_done - b_cpu), 32'd1);

    // CPU read
    b_cpu = n_cpu_done;
    cpu_pulse(1'b1, 23'h000200, 4'b1111, 32'h0);
    wait_req(n);
    check("rd_rnw_addr", 32'({ram_rnw, ram_addr}), 32'h08000200);
    give_done(32'hCAFEF00D);
    @(negedge clk);
    check("rd_cpu_done", 32'(cpu_done), 32'd1);
    check("rd_cpu_do", cpu_do, 32'hCAFEF00D);
    @(negedge clk);
    check("rd_done_pulse_end", 32'(cpu_done), 32'd0);
    tick();
    check("rd_done_count", 32'(n_cpu_done - b_cpu), 32'd1);

    // Three simultaneous requests: DMA, then CPU, then icache
    b_req = n_ram_req; b_cpu = n_cpu_done; b_ic = n_ic_done; b_wr = n_dma_wr; b_done = n_dma_done;
    tick();
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 23'h000300;
    ic_req = 1'b1; ic_addr = 23'h000400;
    dma_req = 1'b1; dma_addr = 23'h000500; dma_cnt = 2'd3;
    tick();
    cpu_req = 1'b0; ic_req = 1'b0; dma_req = 1'b0;
    wait_req(n);
    check("arb_dma_first", 32'({ram_dma, ram_iscache}), 32'h2);
    check("arb_dma_cnt", 32'(ram_dmacnt), 32'd3);
    check("arb_dma_addr", 32'(ram_addr), 32'h0000500);
    tick();
    ram_reqprocessed = 1'b1; ram_dma_wr = 1'b1; ram_dma_data = exp_words[0];
    tick();
    ram_reqprocessed = 1'b0; ram_dma_data = exp_words[1];
    tick();
    ram_dma_wr = 1'b0;
    tick();
    ram_dma_wr = 1'b1; ram_dma_data = exp_words[2];
    tick();
    ram_dma_data = exp_words[3];
    tick();
    ram_dma_wr = 1'b0; ram_dma_data = 32'd0;
    wait_req(n);
    check("dma_word_count", 32'(n_dma_wr - b_wr), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("dma_word%0d", k), dma_log[(b_wr + k) % 16], exp_words[k]);
    check("dma_done_count", 32'(n_dma_done - b_done), 32'd1);
    check("dma_done_on_last", 32'(dma_done_at - b_wr), 32'd4);
    check("arb_cpu_second", 32'({ram_dma, ram_iscache, ram_addr}), 32'h0000300);
    give_done(32'h11112222);
    @(negedge clk);
    check("arb_cpu_do", cpu_do, 32'h11112222);
    wait_req(n);
    check("arb_ic_third", 32'({ram_dma, ram_iscache, ram_addr}), 32'h08000400);
    give_done(32'h0);
    @(negedge clk);
    check("arb_ic_done", 32'(ic_done), 32'd1);
    tick();
    check("arb_req_count", 32'(n_ram_req - b_req), 32'd3);
    check("arb_done_counts", 32'({n_cpu_done - b_cpu, n_ic_done - b_ic}), 32'({32'd1, 32'd1}));

    // ram_idle low holds off the issue
    tick();
    ram_idle = 1'b0;
    b_req = n_ram_req;
    cpu_pulse(1'b0, 23'h000010, 4'hF, 32'h5555AAAA);
    repeat (20) @(negedge clk);
    tick();
    check("stall_no_req", 32'(n_ram_req - b_req), 32'd0);
    ram_idle = 1'b1;
    wait_req(n);
    check("stall_issue_latency", 32'(n), 32'd1);
    give_done(32'h0);

    // Overrun: second CPU pulse while the first is pending
    tick();
    check("ovr_before", 32'(err_overrun), 32'd0);
    ram_idle = 1'b0;
    b_req = n_ram_req; b_cpu = n_cpu_done;
    cpu_pulse(1'b1, 23'h000700, 4'hF, 32'h0);
    cpu_pulse(1'b1, 23'h000704, 4'hF, 32'h0);
    @(negedge clk);
    check("ovr_flag", 32'(err_overrun), 32'd1);
    tick();
    ram_idle = 1'b1;
    wait_req(n);
    check("ovr_first_kept", 32'(ram_addr), 32'h0000700);
    give_done(32'h0BADF00D);
    repeat (10) tick();
    check("ovr_single_done", 32'(n_cpu_done - b_cpu), 32'd1);
    check("ovr_single_req", 32'(n_ram_req - b_req), 32'd1);

`ifdef RAM_TIMEOUT_EN
    // CPU read never answered
    cpu_pulse(1'b1, 23'h000800, 4'hF, 32'h0);
    wait_req(n);
    n = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (cpu_done === 1'b1) begin
        n = i;
        break;
      end
    end
    check("tmo_done_seen", 32'(n >= 0), 32'd1);
    check("tmo_cpu_do", cpu_do, 32'hDEADDEAD);
    check("tmo_err", 32'(err_timeout), 32'd1);
`else
    check("tmo_err_tied", 32'(err_timeout), 32'd0);
`endif

    // Reset in the middle of a DMA burst
    dma_req = 1'b0;
    tick();
    dma_req = 1'b1; dma_addr = 23'h000600; dma_cnt = 2'd2;
    tick();
    dma_req = 1'b0;
    wait_req(n);
    tick();
    ram_reqprocessed = 1'b1; ram_dma_wr = 1'b1; ram_dma_data = 32'h77778888;
    tick();
    ram_reqprocessed = 1'b0; ram_dma_wr = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_dma", 32'({dma_wr, dma_done}), 32'd0);
    check("mid_rst_dma_data", dma_data, 32'd0);
    check("mid_rst_ram", 32'({ram_req, ram_dma, ram_dmacnt, ram_addr}), 32'd0);
    check("mid_rst_err", 32'(err_overrun), 32'd0);
    tick();
    reset = 1'b0;
    b_req = n_ram_req; b_cpu = n_cpu_done; b_ic = n_ic_done; b_wr = n_dma_wr; b_done = n_dma_done;
    ram_dma_wr = 1'b1; ram_dma_data = 32'h99990000; ram_done = 1'b1; ram_reqprocessed = 1'b1;
    repeat (3) tick();
    ram_dma_wr = 1'b0; ram_done = 1'b0; ram_reqprocessed = 1'b0;
    repeat (5) tick();
    check("late_dma_ignored", 32'({n_dma_wr - b_wr, n_dma_done - b_done}), 32'd0);
    check("late_done_ignored", 32'({n_cpu_done - b_cpu, n_ic_done - b_ic, n_ram_req - b_req}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
